// File: rtl/dmem_responder.sv
// Purpose : data-memory responder; posted write buffer drained into a word array, cleared after reset.
// Latency : reads are combinational (same cycle); stores land in the array on a later non-read cycle.
// Backpressure: none toward the pipeline; a store arriving with a full buffer and no drain is dropped (sticky wbuf_overflow).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mem_access_addr          word address, only [ADDR_BITS-1:0] used
//   mem_write_data/_en       store request
//   mem_read_en              load request, ignored when mem_write_en=1
//   mem_read_data            combinational load data (buffer forward, else array, 0 during init)
//   init_busy                array clear in progress
//   wbuf_full/_count         write-buffer occupancy
//   wbuf_overflow            sticky dropped-store flag
module dmem_responder #(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int WBUF_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   mem_access_addr,
   input  logic [DATA_WIDTH-1:0]         mem_write_data,
   input  logic                          mem_write_en,
   input  logic                          mem_read_en,
   output logic [DATA_WIDTH-1:0]         mem_read_data,
   output logic                          init_busy,
   output logic                          wbuf_full,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
   output logic                          wbuf_overflow
);

   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   clear_ptr_q, clear_ptr_d;
   logic                   init_busy_q, init_busy_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   overflow_q, overflow_d;

   // Buffer payload and array carry no reset: validity is tracked by head/count,
   // and the array is explicitly cleared by the init sequence.
   logic [ADDR_BITS-1:0]   wb_addr_q [WBUF_DEPTH];
   logic [DATA_WIDTH-1:0]  wb_data_q [WBUF_DEPTH];
   logic [DATA_WIDTH-1:0]  mem_q     [DEPTH];

   logic [ADDR_BITS-1:0]   addr;
   logic                   is_read;
   logic                   full;
   logic                   drain;
   logic                   enq;
   logic                   drop;
   logic                   arr_we;
   logic [ADDR_BITS-1:0]   arr_waddr;
   logic [DATA_WIDTH-1:0]  arr_wdata;
   logic [PTR_W-1:0]       fwd_idx;
   logic [DATA_WIDTH-1:0]  rdata;

   // Upper address bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^mem_access_addr[15:ADDR_BITS];

   assign addr    = mem_access_addr[ADDR_BITS-1:0];
   assign is_read = mem_read_en & ~mem_write_en;
   assign full    = (count_q == CNT_W'(WBUF_DEPTH));
   // Array port is busy with the read on load cycles, and with clearing during init.
   assign drain   = (state_q == ST_RUN) && (count_q != '0) && !is_read;
   // A full buffer still accepts a store when the head leaves in the same cycle.
   assign enq     = mem_write_en && (!full || drain);
   assign drop    = mem_write_en && full && !drain;

   always_comb begin
      state_d     = state_q;
      clear_ptr_d = clear_ptr_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      overflow_d  = overflow_q | drop;
      arr_we      = 1'b0;
      arr_waddr   = wb_addr_q[head_q];
      arr_wdata   = wb_data_q[head_q];

      if (state_q == ST_INIT) begin
         arr_we      = 1'b1;
         arr_waddr   = clear_ptr_q;
         arr_wdata   = '0;
         clear_ptr_d = clear_ptr_q + 1'b1;
         if (clear_ptr_q == '1) begin
            state_d = ST_RUN;
         end
      end else begin
         arr_we = drain;
      end

      if (drain) begin
         head_d = head_q + 1'b1;
      end
      if (enq) begin
         tail_d = tail_q + 1'b1;
      end
      case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      init_busy_d = (state_d == ST_INIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_INIT;
         clear_ptr_q <= '0;
         init_busy_q <= 1'b1;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clear_ptr_q <= clear_ptr_d;
         init_busy_q <= init_busy_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         wb_addr_q[tail_q] <= addr;
         wb_data_q[tail_q] <= mem_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         mem_q[arr_waddr] <= arr_wdata;
      end
   end

   // Walk valid entries oldest to newest so the newest match wins.
   always_comb begin
      rdata   = (state_q == ST_RUN) ? mem_q[addr] : '0;
      fwd_idx = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (wb_addr_q[fwd_idx] == addr)) begin
            rdata = wb_data_q[fwd_idx];
         end
      end
   end

   assign mem_read_data = rdata;
   assign init_busy     = init_busy_q;
   assign wbuf_full     = full;
   assign wbuf_count    = count_q;
   assign wbuf_overflow = overflow_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose : directed bench for dmem_responder with hand-computed expectations.
// Latency : inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: not applicable; fixed cycle counts, global watchdog.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [15:0] mem_read_data;
   logic        init_busy;
   logic        wbuf_full;
   logic [2:0]  wbuf_count;
   logic        wbuf_overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int icyc    = 0;

   dmem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .mem_access_addr(mem_access_addr),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en),
      .mem_read_en    (mem_read_en),
      .mem_read_data  (mem_read_data),
      .init_busy      (init_busy),
      .wbuf_full      (wbuf_full),
      .wbuf_count     (wbuf_count),
      .wbuf_overflow  (wbuf_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      icyc++;
   endtask

   task automatic drive(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
      mem_write_en    = we;
      mem_read_en     = re;
      mem_access_addr = a;
      mem_write_data  = d;
   endtask

   // Combinational read check: apply a load, let it settle, compare.
   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      drive(1'b0, 1'b1, a, 16'h0000);
      #1;
      chk(tag, {16'h0, mem_read_data}, {16'h0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      // ---- reset state
      chk("rst_busy",  {31'h0, init_busy},     32'h1);
      chk("rst_count", {29'h0, wbuf_count},    32'h0);
      chk("rst_full",  {31'h0, wbuf_full},     32'h0);
      chk("rst_ovf",   {31'h0, wbuf_overflow}, 32'h0);
      rst  = 1'b1;
      icyc = 0;

      // ---- phase 1: stores accumulate during init (no drain before RUN)
      drive(1'b1, 1'b0, 16'h0005, 16'h1111); tick();
      drive(1'b1, 1'b0, 16'h0005, 16'h2222); tick();
      rd_chk("init_fwd_newest", 16'h0005, 16'h2222);
      chk("init_cnt2", {29'h0, wbuf_count}, 32'h2);
      rd_chk("init_no_match_zero", 16'h0007, 16'h0000);
      drive(1'b1, 1'b0, 16'h0007, 16'h3333); tick();
      drive(1'b1, 1'b0, 16'h0009, 16'h4444); tick();
      chk("init_full",  {31'h0, wbuf_full},     32'h1);
      chk("init_cnt4",  {29'h0, wbuf_count},    32'h4);
      chk("init_ovf0",  {31'h0, wbuf_overflow}, 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      while (icyc < 255) tick();
      chk("init_busy_255", {31'h0, init_busy},  32'h1);
      chk("init_nodrain",  {29'h0, wbuf_count}, 32'h4);
      drive(1'b0, 1'b1, 16'h00FF, 16'h0000);
      tick();
      chk("init_done_256", {31'h0, init_busy},  32'h0);
      chk("run_cnt_hold",  {29'h0, wbuf_count}, 32'h4);
      #1;
      chk("rd_ff_cleared", {16'h0, mem_read_data}, 32'h0);

      // full buffer, store on a non-read cycle: drain + enqueue together
      drive(1'b1, 1'b0, 16'h000B, 16'h6666); tick();
      chk("full_swap_cnt",  {29'h0, wbuf_count},    32'h4);
      chk("full_swap_full", {31'h0, wbuf_full},     32'h1);
      chk("full_swap_ovf",  {31'h0, wbuf_overflow}, 32'h0);
      rd_chk("fwd_over_array", 16'h0005, 16'h2222);
      rd_chk("fwd_new_entry",  16'h000B, 16'h6666);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (4) tick();
      chk("drained_cnt", {29'h0, wbuf_count}, 32'h0);
      rd_chk("arr_5", 16'h0005, 16'h2222);
      rd_chk("arr_7", 16'h0007, 16'h3333);
      rd_chk("arr_9", 16'h0009, 16'h4444);
      rd_chk("arr_b", 16'h000B, 16'h6666);

      // forward under continuous reads, then drain on first idle cycle
      drive(1'b1, 1'b0, 16'h0012, 16'hBEEF); tick();
      chk("beef_cnt1", {29'h0, wbuf_count}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         rd_chk("beef_fwd", 16'h0012, 16'hBEEF);
         tick();
         chk("beef_blocked", {29'h0, wbuf_count}, 32'h1);
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000); tick();
      chk("beef_drained", {29'h0, wbuf_count}, 32'h0);
      rd_chk("beef_arr_upper_ignored", 16'hFF12, 16'hBEEF);

      // ---- phase 2: overflow (only reachable while draining is off)
      rst = 1'b0;
      #1;
      chk("rst2_busy",  {31'h0, init_busy},  32'h1);
      chk("rst2_count", {29'h0, wbuf_count}, 32'h0);
      tick();
      rst  = 1'b1;
      icyc = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 16'h0030 + 16'(i), 16'hC000 + 16'(i));
         tick();
         if (i == 3) begin
            chk("ovf_full4", {31'h0, wbuf_full},     32'h1);
            chk("ovf_not_yet", {31'h0, wbuf_overflow}, 32'h0);
         end
      end
      chk("ovf_set", {31'h0, wbuf_overflow}, 32'h1);
      chk("ovf_cnt", {29'h0, wbuf_count},    32'h4);
      rd_chk("ovf_dropped", 16'h0034, 16'h0000);
      rd_chk("ovf_kept",    16'h0033, 16'hC003);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      while (icyc < 256) tick();
      chk("ovf_run", {31'h0, init_busy}, 32'h0);
      repeat (4) tick();
      chk("ovf_drained_cnt", {29'h0, wbuf_count},    32'h0);
      chk("ovf_sticky",      {31'h0, wbuf_overflow}, 32'h1);
      rd_chk("ovf_arr_30", 16'h0030, 16'hC000);
      rd_chk("ovf_arr_33", 16'h0033, 16'hC003);

      // ---- phase 3: reset mid-init with buffered stores
      rst = 1'b0;
      tick();
      rst  = 1'b1;
      icyc = 0;
      drive(1'b1, 1'b0, 16'h0050, 16'h1234); tick();
      drive(1'b1, 1'b0, 16'h0051, 16'h5678); tick();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      while (icyc < 100) tick();
      rd_chk("mid_fwd", 16'h0050, 16'h1234);
      chk("mid_cnt2", {29'h0, wbuf_count}, 32'h2);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy",  {31'h0, init_busy},      32'h1);
      chk("mid_rst_cnt",   {29'h0, wbuf_count},     32'h0);
      chk("mid_rst_ovf",   {31'h0, wbuf_overflow},  32'h0);
      chk("mid_rst_rd",    {16'h0, mem_read_data},  32'h0);
      tick();
      rst  = 1'b1;
      icyc = 0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      while (icyc < 255) tick();
      chk("reinit_busy_255", {31'h0, init_busy}, 32'h1);
      tick();
      chk("reinit_done_256", {31'h0, init_busy}, 32'h0);
      rd_chk("lost_50", 16'h0050, 16'h0000);
      rd_chk("lost_51", 16'h0051, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
